// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the mm:ss clock controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MIN = 2'd1,
    SET_SEC = 2'd2,
    ALM_MIN = 2'd3
  } mode_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_FIVE = 4'd5;

  // Next value of a two-digit BCD counter that runs 00..59 and wraps to 00.
  function automatic logic [7:0] bcd60_next(input bcd_t hi, input bcd_t lo);
    logic [7:0] nxt;
    if (lo != BCD_NINE)      nxt = {hi, lo + 4'd1};
    else if (hi != BCD_FIVE) nxt = {hi + 4'd1, 4'd0};
    else                     nxt = 8'h00;
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59; wrap flags the increment that returns it to 00.
import clock_ctrl_pkg::*;

module bcd_mod60 (
  input  logic       CLK,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] lo,
  output logic [3:0] hi,
  output logic       wrap
);

  assign wrap = inc && (lo == BCD_NINE) && (hi == BCD_FIVE);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      {hi, lo} <= 8'h00;
    end else if (clr) begin
      {hi, lo} <= 8'h00;
    end else if (inc) begin
      {hi, lo} <= bcd60_next(hi, lo);
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// mm:ss clock controller: mode FSM, one-second divider, blink phase, alarm
// duration counter and the display mux for the 7-segment scan logic.
import clock_ctrl_pkg::*;

module clock_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int ALARM_SECS = 10
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alm_en,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       alarm
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] ALM_LOAD   = AW'(ALARM_SECS);
  localparam logic [AW-1:0] ALM_ONE    = AW'(1);

  mode_t         state_q, state_d;
  logic [DW-1:0] div_q;
  logic [BW-1:0] blink_q;
  logic          phase_q;
  logic [AW-1:0] alm_left_q;

  logic       tick, btn_any, inc_ok, fire;
  logic       sec_inc, min_inc, amin_inc;
  logic       sec_wrap, min_wrap_unused, amin_wrap_unused;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, amin_lo, amin_hi;
  logic [7:0] min_next;

  assign tick     = (state_q == RUN) && (div_q == DIV_LAST);
  assign btn_any  = btn_mode | btn_inc;
  // While the alarm sounds, any button only silences it.
  assign inc_ok   = btn_inc & ~btn_mode & ~alarm;
  assign sec_inc  = (state_q == RUN) ? tick     : ((state_q == SET_SEC) & inc_ok);
  assign min_inc  = (state_q == RUN) ? sec_wrap : ((state_q == SET_MIN) & inc_ok);
  assign amin_inc = (state_q == ALM_MIN) & inc_ok;
  assign min_next = bcd60_next(min_hi, min_lo);
  assign fire     = sec_wrap && (state_q == RUN) && alm_en && (min_next == {amin_hi, amin_lo});

  bcd_mod60 u_sec  (.CLK(CLK), .rst(rst), .inc(sec_inc),  .clr(1'b0),
                    .lo(sec_lo),  .hi(sec_hi),  .wrap(sec_wrap));
  bcd_mod60 u_min  (.CLK(CLK), .rst(rst), .inc(min_inc),  .clr(1'b0),
                    .lo(min_lo),  .hi(min_hi),  .wrap(min_wrap_unused));
  bcd_mod60 u_amin (.CLK(CLK), .rst(rst), .inc(amin_inc), .clr(1'b0),
                    .lo(amin_lo), .hi(amin_hi), .wrap(amin_wrap_unused));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (btn_mode && !alarm) begin
      case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        SET_SEC: state_d = ALM_MIN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    blank = 4'b0000;
    d0    = sec_lo;
    d1    = sec_hi;
    d2    = min_lo;
    d3    = min_hi;
    case (state_q)
      SET_MIN: blank = {~phase_q, ~phase_q, 2'b00};
      SET_SEC: blank = {2'b00, ~phase_q, ~phase_q};
      ALM_MIN: begin
        blank = {~phase_q, ~phase_q, 2'b00};
        d3    = amin_hi;
        d2    = amin_lo;
        d1    = 4'd0;
        d0    = 4'd0;
      end
      default: ;
    endcase
  end

  assign mode = state_q;

  // Divider only runs in RUN so re-entry always starts a full second.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      if (state_q != RUN || tick) div_q <= '0;
      else                        div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
      phase_q <= 1'b1;
    end else if (blink_q == BLINK_LAST) begin
      blink_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      blink_q <= blink_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      alarm      <= 1'b0;
      alm_left_q <= '0;
    end else if (!alm_en || (alarm && btn_any)) begin
      alarm <= 1'b0;
    end else if (fire) begin
      alarm      <= 1'b1;
      alm_left_q <= ALM_LOAD;
    end else if (alarm && tick) begin
      if (alm_left_q == ALM_ONE) alarm <= 1'b0;
      alm_left_q <= alm_left_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: directed scenarios plus random button traffic, all
// checked every cycle against an integer-seconds reference model.
module tb_clock_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int BLINK_DIV  = 3;
  localparam int ALARM_SECS = 3;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, alm_en = 1'b0;
  logic [3:0] d0, d1, d2, d3, blank;
  logic [1:0] mode;
  logic       sec_tick, alarm;

  clock_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .CLK(CLK), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc), .alm_en(alm_en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .blank(blank), .mode(mode),
    .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int dut_ticks = 0;
  bit en_lvl = 1'b0;

  // reference model: time as seconds since 00:00, everything else as plain ints
  int m_time, m_alm, m_mode, m_div, m_bcnt, m_left;
  bit m_phase, m_alarm, m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    int s, mi;
    s  = m_time % 60;
    mi = m_time / 60;
    if (m_mode == 3) return {4'(m_alm / 10), 4'(m_alm % 10), 8'h00};
    return {4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] exp_blank();
    logic nb;
    nb = ~m_phase;
    case (m_mode)
      1, 3:    return {nb, nb, 2'b00};
      2:       return {2'b00, nb, nb};
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_time = 0; m_alm = 0; m_mode = 0; m_div = 0; m_bcnt = 0; m_left = 0;
    m_phase = 1'b1; m_alarm = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit bm, input bit bi, input bit en);
    bit tick, inc, old_alarm;
    int s, mi;
    tick      = (m_mode == 0) && (m_div == TICK_DIV - 1);
    old_alarm = m_alarm;
    inc       = bi && !bm && !old_alarm;
    s         = m_time % 60;
    mi        = m_time / 60;
    if (tick)                    m_time = (m_time + 1) % 3600;
    else if (inc && m_mode == 1) m_time = ((mi + 1) % 60) * 60 + s;
    else if (inc && m_mode == 2) m_time = mi * 60 + (s + 1) % 60;
    else if (inc && m_mode == 3) m_alm  = (m_alm + 1) % 60;
    if (!en || (old_alarm && (bm || bi))) m_alarm = 1'b0;
    else if (tick && m_time == m_alm * 60) begin
      m_alarm = 1'b1;
      m_left  = ALARM_SECS;
    end else if (tick && old_alarm) begin
      m_left--;
      if (m_left == 0) m_alarm = 1'b0;
    end
    m_div = (m_mode == 0 && !tick) ? m_div + 1 : 0;
    if (bm && !old_alarm) m_mode = (m_mode + 1) % 4;
    m_bcnt++;
    if (m_bcnt == BLINK_DIV) begin
      m_bcnt  = 0;
      m_phase = ~m_phase;
    end
    m_tick = tick;
  endtask

  task automatic compare_all();
    chk("digits",   {d3, d2, d1, d0}, exp_digits());
    chk("blank",    blank,    exp_blank());
    chk("mode",     mode,     m_mode);
    chk("sec_tick", sec_tick, m_tick);
    chk("alarm",    alarm,    m_alarm);
  endtask

  task automatic cycle(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    alm_en   = en_lvl;
    @(posedge CLK);
    model_step(bm, bi, en_lvl);
    #1;
    if (sec_tick === 1'b1) dut_ticks++;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic inc_n(input int n);
    repeat (n) cycle(1'b0, 1'b1);
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 8 && m_mode != target; i++) cycle(1'b1, 1'b0);
    chk("goto_mode", mode, target);
  endtask

  task automatic set_clock(input int mm, input int ss);
    goto_mode(1);
    inc_n((mm - m_time / 60 + 60) % 60);
    goto_mode(2);
    inc_n((ss - m_time % 60 + 60) % 60);
    goto_mode(0);
  endtask

  // asynchronous assert mid-cycle; outputs must settle before the next edge
  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_digits", {d3, d2, d1, d0}, 16'h0000);
    chk("rst_blank",  blank, 4'h0);
    chk("rst_mode",   mode,  2'd0);
    chk("rst_alarm",  alarm, 1'b0);
    @(posedge CLK);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // free run: 240 cycles -> 60 seconds
    dut_ticks = 0;
    idle(240);
    chk("run240_ticks",  dut_ticks, 60);
    chk("run240_digits", {d3, d2, d1, d0}, 16'h0100);

    // hour rollover
    set_clock(59, 58);
    idle(4);
    chk("carry_5959", {d3, d2, d1, d0}, 16'h5959);
    idle(4);
    chk("carry_0000", {d3, d2, d1, d0}, 16'h0000);

    // seconds wrap in SET_SEC without carry; time frozen
    goto_mode(2);
    inc_n(59);
    chk("setsec_59", {d3, d2, d1, d0}, 16'h0059);
    cycle(1'b0, 1'b1);
    chk("setsec_wrap", {d3, d2, d1, d0}, 16'h0000);
    dut_ticks = 0;
    idle(20);
    chk("hold_ticks",  dut_ticks, 0);
    chk("hold_digits", {d3, d2, d1, d0}, 16'h0000);
    goto_mode(0);
    idle(3);
    chk("reentry_early", sec_tick, 1'b0);
    idle(1);
    chk("reentry_tick", sec_tick, 1'b1);

    // alarm minute edit and alarm window
    set_clock(1, 59);
    goto_mode(3);
    inc_n(2);
    chk("alm_disp", {d3, d2, d1, d0}, 16'h0200);
    idle(9);
    goto_mode(0);
    en_lvl = 1'b1;
    idle(4);
    chk("alm_rise",        alarm, 1'b1);
    chk("alm_rise_digits", {d3, d2, d1, d0}, 16'h0200);
    idle(8);
    chk("alm_hold", alarm, 1'b1);
    idle(4);
    chk("alm_fall",        alarm, 1'b0);
    chk("alm_fall_digits", {d3, d2, d1, d0}, 16'h0203);

    // button silences alarm without acting; mode beats inc
    goto_mode(2);
    inc_n(56);
    goto_mode(3);
    inc_n(1);
    goto_mode(0);
    idle(4);
    chk("alm2_rise", alarm, 1'b1);
    cycle(1'b1, 1'b0);
    chk("btn_clear_alarm", alarm, 1'b0);
    chk("btn_clear_mode",  mode,  2'd0);
    cycle(1'b1, 1'b1);
    chk("mode_wins",     mode, 2'd1);
    chk("mode_wins_min", {d3, d2}, 8'h03);

    // alm_en low clears alarm
    set_clock(3, 59);
    goto_mode(3);
    inc_n(1);
    goto_mode(0);
    idle(4);
    chk("alm3_rise", alarm, 1'b1);
    en_lvl = 1'b0;
    idle(1);
    chk("en_clear", alarm, 1'b0);

    // random button traffic
    en_lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en_lvl = ~en_lvl;
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
    end

    // reset in SET_MIN with a nonzero alarm minute
    en_lvl = 1'b0;
    goto_mode(3);
    inc_n(1);
    if (m_alm == 0) inc_n(1);
    goto_mode(1);
    inc_n(1);
    do_reset();
    goto_mode(3);
    chk("rst_alm_min", {d3, d2, d1, d0}, 16'h0000);
    goto_mode(0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode/time-keeping controller for the board's mm:ss digital clock. It owns the synchronous BCD seconds/minutes chain and generates the one-second tick internally. A 4-state mode FSM lets the user set minutes, seconds and an alarm minute from two button pulses. It drives the four display digits, a per-digit blink mask and an alarm line consumed by the 7-segment scan and buzzer logic.

## Interface
- TICK_DIV, 50_000_000: CLK cycles per second tick (≥2)
- BLINK_DIV, 12_500_000: CLK cycles per blink-phase toggle (≥1)
- ALARM_SECS, 10: seconds the alarm stays asserted (≥1)
- CLK  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- btn_mode  in  1  one-cycle pulse (already debounced), advance mode
- btn_inc  in  1  one-cycle pulse (already debounced), increment field being edited
- alm_en  in  1  level, alarm enable
- d0, d1, d2, d3  out  4 each  displayed BCD digits: sec_lo, sec_hi, min_lo, min_hi
- blank  out  4  bit i=1 → digit i must be blanked
- mode  out  2  current FSM state encoding
- sec_tick  out  1  one-cycle pulse on every second-tick while in RUN
- alarm  out  1  alarm/buzzer request

## Operation
- States: RUN=0, SET_MIN=1, SET_SEC=2, ALM_MIN=3. btn_mode: RUN→SET_MIN→SET_SEC→ALM_MIN→RUN.
- RUN: divider counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0, pulses sec_tick and increments time. Seconds 59→00 carries into minutes; 59:59→00:00. The carry is synchronous; no derived clocks.
- SET_MIN: btn_inc increments minutes 00..59 and wraps to 00 with no carry. SET_SEC: same on seconds, no carry into minutes. ALM_MIN: same on the alarm-minute register.
- In every non-RUN state, the divider is held at 0 and time does not advance. Re-entering RUN starts a full TICK_DIV period.
- Display mux: d0..d3 show current time, except in ALM_MIN, where d3/d2 show alarm minutes and d1=d0=0.
- Blink: a free-running counter toggles `phase` every BLINK_DIV cycles in all states.
  - SET_MIN and ALM_MIN: blank = {~phase, ~phase, 0, 0}.
  - SET_SEC: blank = {0, 0, ~phase, ~phase}.
  - RUN: blank = 0000.
- Alarm fires in RUN when a tick produces time == alm_min:00 while alm_en=1. It stays high for ALARM_SECS subsequent ticks and then clears.
- While alarm=1, any btn_mode or btn_inc clears alarm and is consumed: no mode change, no increment. alm_en=0 clears alarm.
- btn_mode and btn_inc in the same cycle: mode wins, inc ignored.

## Timing
- Reset (async assert, values hold until deassert):
  - d0..d3=0, alarm minutes=0, mode=RUN, divider=0, blink counter=0, phase=1.
  - blank=0000, sec_tick=0, alarm=0.
- All outputs are registered or decoded from registers. mode, digits and blank update on the edge that samples a button: one-cycle latency from pulse to output.
- sec_tick is high in the cycle after the divider reaches TICK_DIV-1. The digits change on that same edge.
- alarm rises on the same edge as the matching digit update. It falls on the edge of the ALARM_SECS-th following tick, or on the edge sampling a clearing button, or on the first edge with alm_en=0.
- Reset mid-operation (e.g. during SET_SEC or alarm) returns everything to reset values immediately.

## Structure
- Package clock_ctrl_pkg:
  - mode encoding constants RUN/SET_MIN/SET_SEC/ALM_MIN
  - 4-bit BCD digit type
  - constant 4'd9 and constant 4'd5
- Sub-module bcd_mod60:
  - ports: CLK, rst, inc, clr, lo[3:0], hi[3:0], wrap (combinational: inc while value==59)
  - instantiated three times: seconds, minutes, alarm minutes
- The top contains the FSM, divider, blink counter, alarm counter and display mux.

## Test plan
All scenarios use TICK_DIV=4, BLINK_DIV=3, ALARM_SECS=3.
- Reset then 240 cycles in RUN → 60 sec_tick pulses, digits read 01:00. sec_tick is exactly one cycle wide every 4 cycles.
- Load 59:58 via SET modes, return to RUN, run 8 cycles → 59:59, then 00:00; min digits wrap without glitch.
- SET_SEC at 00:59 with one btn_inc → 00:00 and minutes unchanged. Divider stays 0 over 20 cycles, with no sec_tick.
- ALM_MIN with 2× btn_inc → d3..d0 = 0,2,0,0, blank[3:2] toggling every 3 cycles. RUN from 01:59 with alm_en=1 → alarm rises at 02:00 and falls at 02:03.
- Alarm high, btn_mode pulse → alarm=0 next edge and mode stays RUN. btn_mode+btn_inc together in RUN → mode=SET_MIN, minutes unchanged.
- Assert rst mid-SET_MIN with alarm minute set → all outputs at reset values before the next CLK edge, and alarm minute=00.
